// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver: per-frame shadow latch, dead-time
// blanking between digits, leading-zero suppression and an optional blink gate.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_DIV = 50000000,
    parameter int LZ_BLANK  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] seg_value,
    input  logic        blink_en,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out,
    output logic        frame_tick
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {
        PH_ON,
        PH_OFF
    } phase_t;

    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [23:0]   shadow;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    phase_t        blink_phase, blink_phase_nxt;

    logic          scan_wrap;
    logic          frame_wrap;
    logic [7:0]    supp;
    logic [31:0]   shadow_ext;
    logic [3:0]    nibble;
    logic [6:0]    seg7;
    logic          display_on;
    logic          lit;
    logic          above_nz;

    assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
    assign frame_wrap = scan_wrap && (digit_idx == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            shadow    <= '0;
        end else begin
            if (scan_wrap) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (frame_wrap)
                shadow <= seg_value;
        end
    end

    always_comb begin
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        if (!blink_en) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = PH_ON;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = (blink_phase == PH_ON) ? PH_OFF : PH_ON;
        end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= PH_ON;
        end else begin
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
        end
    end

    // Walk from the top digit down: a digit is blank while everything above and including it is zero.
    always_comb begin
        supp     = '0;
        above_nz = 1'b0;
        for (int unsigned k = 5; k >= 1; k--) begin
            above_nz = above_nz | (|shadow[4*k +: 4]);
            supp[k]  = (LZ_BLANK != 0) && !above_nz;
        end
    end

    assign shadow_ext = {8'h00, shadow};
    assign nibble     = shadow_ext[4*digit_idx +: 4];

    always_comb begin
        seg7 = 7'h00;
        case (nibble)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            4'hF: seg7 = 7'h71;
            default: seg7 = 7'h00;
        endcase
    end

    // blink_en is folded in directly so dropping it relights the display on the very next output cycle.
    assign display_on = !blink_en || (blink_phase == PH_ON);
    assign lit = (scan_cnt >= SW'(BLANK_CYC)) && (digit_idx <= 3'd5)
                 && !supp[digit_idx] && display_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_an     <= '0;
            seg_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_an     <= lit ? (8'h01 << digit_idx) : 8'h00;
            seg_out    <= lit ? {1'b0, seg7} : 8'h00;
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a 4-cycle digit slot and 40-cycle blink half-period.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        blink_en = 1'b0;
    logic [23:0] seg_value = 24'hFFFFFF;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc = -1;

    logic [6:0] dec [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV (4),
        .BLANK_CYC(1),
        .BLINK_DIV(40),
        .LZ_BLANK (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_value (seg_value),
        .blink_en  (blink_en),
        .seg_an    (seg_an),
        .seg_out   (seg_out),
        .frame_tick(frame_tick)
    );

    // cyc = index of the post-reset scan cycle whose state the outputs now reflect
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full 32-cycle frame; expectation derived from the displayed word.
    task automatic expect_frame(input logic [23:0] shown, input int chg_at,
                                input logic [23:0] chg_val, input string tag);
        logic [31:0] ext;
        logic [7:0]  exp_an, exp_seg;
        logic        supp, lit, exp_ft;
        int          slot, pos;
        ext = {8'h00, shown};
        for (int i = 0; i < 32; i++) begin
            step();
            slot    = (cyc / 4) % 8;
            pos     = cyc % 4;
            supp    = (slot >= 1) && (slot <= 5) && ((ext >> (4 * slot)) == 32'h0);
            lit     = (pos >= 1) && (slot <= 5) && !supp;
            exp_an  = lit ? (8'h01 << slot) : 8'h00;
            exp_seg = lit ? {1'b0, dec[ext[4*slot +: 4]]} : 8'h00;
            exp_ft  = (cyc % 32) == 31;
            checks += 3;
            if (seg_an !== exp_an) begin
                errors++;
                $display("FAIL %s seg_an cyc=%0d got=%h exp=%h", tag, cyc, seg_an, exp_an);
            end
            if (seg_out !== exp_seg) begin
                errors++;
                $display("FAIL %s seg_out cyc=%0d got=%h exp=%h", tag, cyc, seg_out, exp_seg);
            end
            if (frame_tick !== exp_ft) begin
                errors++;
                $display("FAIL %s frame_tick cyc=%0d got=%b exp=%b", tag, cyc, frame_tick, exp_ft);
            end
            if (i == chg_at) seg_value = chg_val;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks += 3;
            if (seg_an !== 8'h00) begin
                errors++;
                $display("FAIL reset seg_an got=%h exp=00", seg_an);
            end
            if (seg_out !== 8'h00) begin
                errors++;
                $display("FAIL reset seg_out got=%h exp=00", seg_out);
            end
            if (frame_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset frame_tick got=%b exp=0", frame_tick);
            end
        end
        rst = 1'b0;
        seg_value = 24'h123456;
        cyc = -1;
        expect_frame(24'h000000, -1, 24'h0, "reset_frame");
    endtask

    task automatic test_scan_order();
        expect_frame(24'h123456, -1, 24'h0, "scan_order");
    endtask

    task automatic test_tear_free();
        expect_frame(24'h123456, 9, 24'hABCDEF, "tear_old");
        expect_frame(24'hABCDEF, 0, 24'h0000A0, "tear_new");
    endtask

    task automatic test_leading_zero();
        expect_frame(24'h0000A0, 0, 24'h000000, "lz_a0");
        expect_frame(24'h000000, 0, 24'h000008, "lz_zero");
    endtask

    task automatic test_blink();
        int   c0, b, slot, pos;
        logic dropped, exp_on, lit;
        c0 = cyc;
        blink_en = 1'b1;
        dropped = 1'b0;
        for (int n = 0; n < 170; n++) begin
            step();
            b      = cyc - c0 - 1;
            slot   = (cyc / 4) % 8;
            pos    = cyc % 4;
            exp_on = dropped || ((b / 40) % 2 == 0);
            lit    = exp_on && (slot == 0) && (pos >= 1);
            checks += 3;
            if (seg_an !== (lit ? 8'h01 : 8'h00)) begin
                errors++;
                $display("FAIL blink seg_an cyc=%0d got=%h exp=%h", cyc, seg_an, lit ? 8'h01 : 8'h00);
            end
            if (seg_out !== (lit ? 8'h7F : 8'h00)) begin
                errors++;
                $display("FAIL blink seg_out cyc=%0d got=%h exp=%h", cyc, seg_out, lit ? 8'h7F : 8'h00);
            end
            if (frame_tick !== ((cyc % 32) == 31)) begin
                errors++;
                $display("FAIL blink frame_tick cyc=%0d got=%b", cyc, frame_tick);
            end
            if (!dropped && b == 125) begin
                blink_en = 1'b0;
                dropped = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid();
        int   c1, b;
        logic found;
        seg_value = 24'h123456;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (frame_tick === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_latch_timeout got=none exp=frame_tick");
        end
        blink_en = 1'b1;
        c1 = cyc;
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            step();
            b = cyc - c1 - 1;
            if ((cyc / 4) % 8 == 3 && cyc % 4 == 2) begin
                if ((b / 40) % 2 == 1) begin
                    found = 1'b1;
                end else begin
                    checks++;
                    if (seg_an !== 8'h08 || seg_out !== 8'h4F) begin
                        errors++;
                        $display("FAIL mid_digit3_on got=%h/%h exp=08/4F", seg_an, seg_out);
                    end
                end
            end
        end
        checks++;
        if (!found || seg_an !== 8'h00) begin
            errors++;
            $display("FAIL mid_off_phase found=%b seg_an got=%h exp=00", found, seg_an);
        end
        rst = 1'b1;
        step();
        checks += 3;
        if (seg_an !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst seg_an got=%h exp=00", seg_an);
        end
        if (seg_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst seg_out got=%h exp=00", seg_out);
        end
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst frame_tick got=%b exp=0", frame_tick);
        end
        rst = 1'b0;
        cyc = -1;
        expect_frame(24'h000000, -1, 24'h0, "mid_restart");
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_leading_zero();
        test_blink();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
